// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_pkg
//  Brief    : Shared types and constants for the byte-enabled dual-port RAM.
//  Revision : 1.0
// ============================================================================
package dpram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        RD_FIRST = 1'b0,
        WR_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic [0:0] {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage : dpram_pkg
`default_nettype wire

// File: rtl/dpram_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_rd_pipe
//  Brief    : Read-data/valid delay line, RD_LAT stages; data holds when idle.
//  Revision : 1.0
// ============================================================================
module dpram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data
);

    logic [RD_LAT-1:0] r_vld;
    logic [DATA_W-1:0] r_data [RD_LAT];

    // Each stage only loads on a valid beat so the output keeps its last word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_data[s] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            if (i_vld) begin
                r_data[0] <= i_data;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_data[s] <= r_data[s-1];
                end
            end
        end
    end

    assign o_vld  = r_vld[RD_LAT-1];
    assign o_data = r_data[RD_LAT-1];

endmodule : dpram_rd_pipe
`default_nettype wire

// File: rtl/dpram_bwe.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_bwe
//  Brief    : True dual-port RAM with byte enables, RD_LAT read pipe,
//             write-write collision priority and post-reset array clear.
//  Revision : 1.0
// ============================================================================
module dpram_bwe
    import dpram_pkg::*;
#(
    parameter int        DATA_W    = 32,
    parameter int        ADDR_W    = 6,
    parameter int        RD_LAT    = 1,
    parameter rdw_mode_e RDW_MODE  = RD_FIRST,
    parameter prio_e     COLL_PRIO = PRIO_A
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic                     en_a,
    input  logic [DATA_W/BYTE_W-1:0] we_a,
    input  logic [ADDR_W-1:0]        addr_a,
    input  logic [DATA_W-1:0]        datain_a,
    output logic [DATA_W-1:0]        dataout_a,
    output logic                     valid_a,
    input  logic                     en_b,
    input  logic [DATA_W/BYTE_W-1:0] we_b,
    input  logic [ADDR_W-1:0]        addr_b,
    input  logic [DATA_W-1:0]        datain_b,
    output logic [DATA_W-1:0]        dataout_b,
    output logic                     valid_b,
    output logic                     collision
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    if ((DATA_W % BYTE_W) != 0) begin : g_bad_width
        $fatal(1, "dpram_bwe: DATA_W must be a multiple of 8");
    end
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_lat
        $fatal(1, "dpram_bwe: RD_LAT must be 1 or 2");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_e            r_state;
    logic [ADDR_W-1:0] r_clear_ptr;
    logic              r_init_done;
    logic              r_collision;

    logic              w_acc_a, w_acc_b;
    logic [NB-1:0]     w_wr_a, w_wr_b, w_ovl, w_keep_a, w_keep_b;
    logic [DATA_W-1:0] w_old_a, w_old_b, w_mrg_a, w_mrg_b, w_rd_a, w_rd_b;

    assign w_acc_a = (r_state == ST_READY) && en_a;
    assign w_acc_b = (r_state == ST_READY) && en_b;
    assign w_wr_a  = {NB{w_acc_a}} & we_a;
    assign w_wr_b  = {NB{w_acc_b}} & we_b;
    assign w_ovl   = (addr_a == addr_b) ? (w_wr_a & w_wr_b) : '0;

    // Overlapping lanes are dropped from the losing port so only one write lands.
    assign w_keep_a = w_wr_a & ~((COLL_PRIO == PRIO_B) ? w_ovl : '0);
    assign w_keep_b = w_wr_b & ~((COLL_PRIO == PRIO_A) ? w_ovl : '0);

    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clear_ptr] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (w_keep_a[i]) begin
                    r_mem[addr_a][i*BYTE_W +: BYTE_W] <= datain_a[i*BYTE_W +: BYTE_W];
                end
                if (w_keep_b[i]) begin
                    r_mem[addr_b][i*BYTE_W +: BYTE_W] <= datain_b[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_CLEAR;
            r_clear_ptr <= '0;
            r_init_done <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_collision <= |w_ovl;
            case (r_state)
                ST_CLEAR: begin
                    r_clear_ptr <= r_clear_ptr + 1'b1;
                    if (r_clear_ptr == '1) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign w_old_a = r_mem[addr_a];
    assign w_old_b = r_mem[addr_b];

    // Write-first view is the port's own merge; the other port never affects it.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign w_mrg_a[gi*BYTE_W +: BYTE_W] = we_a[gi] ? datain_a[gi*BYTE_W +: BYTE_W]
                                                       : w_old_a[gi*BYTE_W +: BYTE_W];
        assign w_mrg_b[gi*BYTE_W +: BYTE_W] = we_b[gi] ? datain_b[gi*BYTE_W +: BYTE_W]
                                                       : w_old_b[gi*BYTE_W +: BYTE_W];
    end

    assign w_rd_a = (RDW_MODE == WR_FIRST) ? w_mrg_a : w_old_a;
    assign w_rd_b = (RDW_MODE == WR_FIRST) ? w_mrg_b : w_old_b;

    dpram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe_a (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_acc_a),
        .i_data (w_rd_a),
        .o_vld  (valid_a),
        .o_data (dataout_a)
    );

    dpram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe_b (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_acc_b),
        .i_data (w_rd_b),
        .o_vld  (valid_b),
        .o_data (dataout_b)
    );

    assign init_done = r_init_done;
    assign collision = r_collision;

endmodule : dpram_bwe
`default_nettype wire

// File: doc/dpram_bwe.md
Name: dpram_bwe

Overview:
- Parametrised true dual-port RAM; successor to the fixed-size dpram.
- Adds per-byte write enables, 1- or 2-cycle read latency with valid flags, and configurable same-port read-during-write behaviour.
- Adds deterministic write-write collision resolution with a collision flag, and a hardware clear sequencer that zeroes the array after every reset.
- Sits wherever dpram sits today: two independent masters share one storage array on one clock.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8. NB = DATA_W/8 byte lanes.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, RD_FIRST, same-port read-during-write result; RD_FIRST returns old data, WR_FIRST returns new merged data.
- COLL_PRIO, PRIO_A, port that owns overlapping byte lanes on a same-address dual write.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- init_done  output  1  high once the array clear has completed
- en_a  input  1  port A access request
- we_a  input  NB  port A byte write enables; 0 = read only
- addr_a  input  ADDR_W  port A address
- datain_a  input  DATA_W  port A write data
- dataout_a  output  DATA_W  port A read data
- valid_a  output  1  dataout_a valid strobe
- en_b, we_b, addr_b, datain_b, dataout_b, valid_b: same as port A, for port B
- collision  output  1  one-cycle pulse on a same-address write-write overlap

Behaviour:
- Reset (rst=0, asynchronous):
  - dataout_a/b=0, valid_a/b=0, collision=0, init_done=0.
  - Read pipelines flushed; FSM forced to ST_CLEAR; clear_ptr=0.
- ST_CLEAR:
  - Each cycle writes 0 to mem[clear_ptr], then increments clear_ptr.
  - The write of DEPTH-1 moves the FSM to ST_READY; init_done rises on that edge, i.e. DEPTH edges after rst deasserts.
  - All port requests are ignored: no writes, valid stays 0.
- ST_READY: an access is accepted on any cycle with en_x=1.
  - Write: byte lane i of mem[addr_x] is updated from datain_x when we_x[i]=1; other lanes unchanged.
  - Every accepted access, read or write, returns data: valid_x=1 exactly RD_LAT cycles after acceptance, with dataout_x aligned to it.
  - RD_LAT=1: registered array read. RD_LAT=2: one additional output register.
  - dataout_x holds its last value while valid_x=0.
- Same-port read-during-write (governed by RDW_MODE):
  - RD_FIRST: dataout is the pre-write word.
  - WR_FIRST: dataout is the merged post-write word; lanes with enable 0 keep old bytes.
- Cross-port: a read on one port of an address the other port writes in the same cycle always returns old data, independent of RDW_MODE.
- Dual write to the same address in the same cycle:
  - Lanes enabled on only one port take that port's data.
  - Lanes enabled on both ports take the COLL_PRIO port's data.
  - collision=1 on the following cycle only if at least one lane overlapped.
- Different addresses: fully independent; no interaction, no collision.
- Address wrap: addresses are exactly ADDR_W bits; no out-of-range case exists.
- Reset mid-operation: in-flight reads are dropped (valid never asserts for them) and the full clear sequence reruns.
- RD_LAT outside {1,2}, or DATA_W not a multiple of 8: elaboration-time fatal assertion.

Decomposition:
- Package dpram_pkg holds:
  - rdw_mode_e {RD_FIRST, WR_FIRST}
  - prio_e {PRIO_A, PRIO_B}
  - state_e {ST_CLEAR, ST_READY}
  - byte lane constant BYTE_W=8
- Sub-module dpram_rd_pipe, parametrised by DATA_W and RD_LAT: carries data and valid through the latency stages, with async clear. Instantiated once per port.
- The top level holds the array, byte-merge logic, collision resolution and the clear FSM.

Test Plan (DATA_W=32, ADDR_W=4, RD_LAT=1 unless stated):
- Release rst at cycle 0 -> init_done rises at edge 16; then A reads addr 12 -> valid_a next cycle, dataout_a=0x00000000.
- A writes addr 3 0xDEADBEEF, we_a=4'hF; next cycle B reads addr 3 -> dataout_b=0xDEADBEEF with valid_b one cycle later.
- A writes addr 5 0x11223344 (we=F), then 0xAABBCCDD with we=4'b0010 -> read of addr 5 returns 0x1122CC44.
- Same-cycle writes to addr 7: A 0xAAAAAAAA we=F, B 0x55555555 we=4'b0011 -> PRIO_A stores 0xAAAAAAAA, PRIO_B stores 0xAAAA5555; collision=1 for exactly one cycle.
- addr 9 holds 0x1; A writes 0x2 with we=F -> same-cycle dataout_a=0x1 (RD_FIRST) or 0x2 (WR_FIRST); B reading addr 9 that cycle returns 0x1 in both modes.
- RD_LAT=2: A reads addr 3 (0xDEADBEEF), rst asserted one cycle later -> valid_a never pulses; after release and re-clear, addr 3 reads 0.
